// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C driver between the altimeter (0) and IMU (1) controllers.
// Optional grant-hold timeout is built only when I2C_ARB_TIMEOUT_EN is defined.
module i2c_bus_arbiter #(
    parameter int GUARD_CYCLES = 4,
    parameter int HOLD_MAX     = 2000000,
    parameter int HOLD_W       = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  m_ena,
    input  logic [1:0]  m_rw,
    input  logic [15:0] m_data_wr,
    input  logic [1:0]  m_start,
    input  logic [1:0]  m_stop,
    input  logic [1:0]  m_rstart,
    output logic [15:0] m_data_rd,
    output logic [1:0]  m_busy,
    output logic [1:0]  m_ready,
    output logic [1:0]  m_ack_err,
    output logic        drv_ena,
    output logic        drv_rw,
    output logic        drv_start,
    output logic        drv_stop,
    output logic        drv_rstart,
    output logic [7:0]  drv_data_wr,
    input  logic [7:0]  drv_data_rd,
    input  logic        drv_busy,
    input  logic        drv_ready,
    input  logic        drv_ack_err,
    output logic        timeout
);
    // state   | meaning
    // IDLE    | bus free, pick a winner from pending requests
    // GRANT   | one requester owns the driver
    // RELEASE | grant dropped, waiting for the driver to go idle
    // GUARD   | counting GUARD_CYCLES consecutive idle cycles before regrant
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE, GUARD} state_t;

    localparam int GW = $clog2(GUARD_CYCLES + 1);

    if (HOLD_W < 1 || (64'd1 << HOLD_W) <= 64'(HOLD_MAX)) begin : g_hold_w_check
        $error("HOLD_W too narrow for HOLD_MAX");
    end

    state_t        state;
    logic          last;
    logic [GW-1:0] guard_cnt;
    logic [1:0]    cand;
    logic          win;
    logic          stop_pulse;
    logic [1:0]    blocked;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;
`else
    assign stop_pulse = 1'b0;
    assign blocked    = 2'b00;
    assign timeout    = 1'b0;
`endif

    // A revoked requester stays masked until it drops its request.
    assign cand = req & ~blocked;

    always_comb begin
        win = cand[1];
        if (cand == 2'b11) win = ~last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            last      <= 1'b1;
            guard_cnt <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            hold_cnt   <= '0;
            timeout    <= 1'b0;
            stop_pulse <= 1'b0;
            blocked    <= 2'b00;
`endif
        end else begin
`ifdef I2C_ARB_TIMEOUT_EN
            stop_pulse <= 1'b0;
            blocked    <= blocked & req;
`endif
            case (state)
                IDLE: begin
                    if (|cand) begin
                        gnt   <= win ? 2'b10 : 2'b01;
                        last  <= win;
                        state <= GRANT;
`ifdef I2C_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!(|(req & gnt))) begin
                        gnt   <= 2'b00;
                        state <= RELEASE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_W'(HOLD_MAX - 1)) begin
                        gnt        <= 2'b00;
                        stop_pulse <= 1'b1;
                        timeout    <= 1'b1;
                        blocked    <= (blocked & req) | gnt;
                        state      <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (!drv_busy) begin
                        guard_cnt <= '0;
                        state     <= GUARD;
                    end
                end
                GUARD: begin
                    if (drv_busy) guard_cnt <= '0;
                    else if (guard_cnt == GW'(GUARD_CYCLES - 1)) state <= IDLE;
                    else guard_cnt <= guard_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command mux and status demux follow the registered grant only.
    always_comb begin
        drv_ena     = 1'b0;
        drv_rw      = 1'b0;
        drv_start   = 1'b0;
        drv_stop    = stop_pulse;
        drv_rstart  = 1'b0;
        drv_data_wr = 8'h00;
        m_busy      = 2'b11;
        m_ready     = 2'b00;
        m_ack_err   = 2'b00;
        m_data_rd   = 16'h0000;
        if (gnt[0]) begin
            drv_ena         = m_ena[0];
            drv_rw          = m_rw[0];
            drv_start       = m_start[0];
            drv_stop        = m_stop[0];
            drv_rstart      = m_rstart[0];
            drv_data_wr     = m_data_wr[7:0];
            m_busy[0]       = drv_busy;
            m_ready[0]      = drv_ready;
            m_ack_err[0]    = drv_ack_err;
            m_data_rd[7:0]  = drv_data_rd;
        end else if (gnt[1]) begin
            drv_ena         = m_ena[1];
            drv_rw          = m_rw[1];
            drv_start       = m_start[1];
            drv_stop        = m_stop[1];
            drv_rstart      = m_rstart[1];
            drv_data_wr     = m_data_wr[15:8];
            m_busy[1]       = drv_busy;
            m_ready[1]      = drv_ready;
            m_ack_err[1]    = drv_ack_err;
            m_data_rd[15:8] = drv_data_rd;
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios plus random traffic against a timestamp-based model.
module tb_i2c_bus_arbiter;
    localparam int GUARD  = 4;
    localparam int HOLD_M = 100;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, gnt, m_ena, m_rw, m_start, m_stop, m_rstart;
    logic [15:0] m_data_wr, m_data_rd;
    logic [1:0]  m_busy, m_ready, m_ack_err;
    logic        drv_ena, drv_rw, drv_start, drv_stop, drv_rstart;
    logic [7:0]  drv_data_wr, drv_data_rd;
    logic        drv_busy, drv_ready, drv_ack_err, timeout;

    i2c_bus_arbiter #(.GUARD_CYCLES(GUARD), .HOLD_MAX(HOLD_M), .HOLD_W(21)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .m_ena(m_ena), .m_rw(m_rw), .m_data_wr(m_data_wr), .m_start(m_start),
        .m_stop(m_stop), .m_rstart(m_rstart), .m_data_rd(m_data_rd), .m_busy(m_busy),
        .m_ready(m_ready), .m_ack_err(m_ack_err), .drv_ena(drv_ena), .drv_rw(drv_rw),
        .drv_start(drv_start), .drv_stop(drv_stop), .drv_rstart(drv_rstart),
        .drv_data_wr(drv_data_wr), .drv_data_rd(drv_data_rd), .drv_busy(drv_busy),
        .drv_ready(drv_ready), .drv_ack_err(drv_ack_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: who owns the bus, and timestamps of the release handshake.
    int owner, last_w, held, rel_done, last_high, edge_n;
    bit open_b, stop_exp, to_exp;
    bit [1:0] blocked_m;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; last_w = 1; held = 0; open_b = 1'b1;
        stop_exp = 1'b0; to_exp = 1'b0; blocked_m = 2'b00;
        rel_done = -1; last_high = -1;
    endtask

    task automatic start_release();
        owner = -1; rel_done = -1; last_high = -1; open_b = 1'b0;
    endtask

    task automatic model_edge();
        bit [1:0] nb, eff;
        int ref_t;
        edge_n++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        stop_exp = 1'b0;
        nb = blocked_m & req;
        if (owner >= 0) begin
            if (!req[owner]) start_release();
            else if (TO_EN) begin
                held++;
                if (held == HOLD_M) begin
                    nb[owner] = 1'b1;
                    stop_exp = 1'b1;
                    to_exp = 1'b1;
                    start_release();
                end
            end
        end else if (open_b) begin
            eff = req & ~blocked_m;
            if (eff != 2'b00) begin
                owner = (eff == 2'b11) ? 1 - last_w : (eff[1] ? 1 : 0);
                last_w = owner;
                held = 0;
            end
        end else if (rel_done < 0) begin
            if (!drv_busy) rel_done = edge_n;
        end else if (drv_busy) begin
            last_high = edge_n;
        end else begin
            ref_t = (rel_done > last_high) ? rel_done : last_high;
            if (edge_n - ref_t >= GUARD) open_b = 1'b1;
        end
        blocked_m = nb;
    endtask

    task automatic check_all();
        logic [1:0]  eg, eb, er, ea;
        logic [4:0]  ecmd;
        logic [7:0]  edw;
        logic [15:0] erd;
        eg = 2'b00; eb = 2'b11; er = 2'b00; ea = 2'b00; erd = 16'h0; edw = 8'h0;
        ecmd = {3'b000, stop_exp, 1'b0};
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ecmd = {m_ena[owner], m_rw[owner], m_start[owner], m_stop[owner], m_rstart[owner]};
            edw = m_data_wr[owner*8 +: 8];
            eb[owner] = drv_busy;
            er[owner] = drv_ready;
            ea[owner] = drv_ack_err;
            erd[owner*8 +: 8] = drv_data_rd;
        end
        chk("gnt", gnt, eg);
        chk("drv_cmd", {drv_ena, drv_rw, drv_start, drv_stop, drv_rstart}, ecmd);
        chk("drv_data_wr", drv_data_wr, edw);
        chk("m_data_rd", m_data_rd, erd);
        chk("m_busy", m_busy, eb);
        chk("m_ready_ack", {m_ready, m_ack_err}, {er, ea});
        chk("timeout", timeout, to_exp);
    endtask

    // Inputs for this cycle are already applied; check, then advance one clock.
    task automatic step();
        #1 check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_side();
        m_ena = 2'($urandom); m_rw = 2'($urandom); m_start = 2'($urandom);
        m_stop = 2'($urandom); m_rstart = 2'($urandom); m_data_wr = 16'($urandom);
        drv_data_rd = 8'($urandom); drv_ready = 1'($urandom); drv_ack_err = 1'($urandom);
    endtask

    task automatic wait_gnt(input string tag, output int cycles);
        cycles = 0;
        while (gnt == 2'b00 && cycles < 60) begin
            step();
            cycles++;
        end
        chk(tag, (gnt != 2'b00), 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        logic [1:0] exp_g;
        edge_n = 0;
        model_reset();
        req = 2'b00; drv_busy = 1'b0; rst_n = 1'b0;
        rand_side();
        #2 check_all();
        do_reset();

        // First grant goes to requester 0, one cycle after req.
        m_data_wr = 16'h33EE; m_ena = 2'b11; req = 2'b01;
        step();
        chk("gnt_latency", gnt, 2'b01);
        chk("drv_data_wr_ee", drv_data_wr, 8'hEE);
        drv_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("idle_req1_busy", {m_busy[1], m_ready[1]}, 2'b10);
        end
        req = 2'b00; drv_busy = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Both held: grants alternate, each regrant only after the guard window.
        do_reset();
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt("rr_wait", gap);
            if (k > 0) chk("regrant_gap", (gap >= GUARD + 1), 1'b1);
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_seq", gnt, exp_g);
            drv_busy = 1'b1;
            for (int i = 0; i < 10; i++) begin rand_side(); step(); end
            drv_busy = 1'b0;
            req = 2'b11 & ~gnt;
            step();
            req = 2'b11;
        end
        req = 2'b00;
        for (int i = 0; i < 8; i++) step();

        // Read data and ready reach only the granted requester.
        req = 2'b10;
        wait_gnt("rd_wait", gap);
        drv_data_rd = 8'h5A; drv_ready = 1'b1; drv_ack_err = 1'b0;
        step();
        chk("rd_pass", {m_data_rd, m_ready}, {16'h5A00, 2'b10});
        req = 2'b00;
        for (int i = 0; i < 8; i++) step();

        // Requester 0 drops while the driver stays busy; the other waits out the guard.
        req = 2'b01;
        wait_gnt("busy_wait", gap);
        drv_busy = 1'b1; req = 2'b10;
        for (int i = 0; i < 20; i++) begin
            rand_side();
            step();
            chk("held_off", gnt, 2'b00);
        end
        drv_busy = 1'b0;
        wait_gnt("guard_wait", gap);
        chk("guard_gap", (gap >= GUARD + 1), 1'b1);

        // Asynchronous reset in the middle of a grant.
        m_ena = 2'b11; m_start = 2'b11; m_data_wr = 16'hFFFF;
        step();
        rst_n = 1'b0;
        #2;
        chk("arst_gnt", gnt, 2'b00);
        chk("arst_cmd", {drv_ena, drv_start, drv_data_wr}, 10'h000);
        chk("arst_to", timeout, 1'b0);
        model_reset();
        step();
        rst_n = 1'b1; req = 2'b00;
        step();

`ifdef I2C_ARB_TIMEOUT_EN
        // Hold requester 0 past HOLD_MAX: forced stop, sticky flag, no regrant until req cycles.
        req = 2'b01; m_stop = 2'b00;
        for (int i = 0; i < HOLD_M + 20; i++) step();
        chk("to_flag", timeout, 1'b1);
        chk("to_no_regrant", gnt, 2'b00);
        req = 2'b00;
        step();
        req = 2'b01;
        wait_gnt("to_regrant", gap);
        req = 2'b00;
        for (int i = 0; i < 8; i++) step();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_side();
            if ($urandom_range(9) == 0) req[0] = ~req[0];
            if ($urandom_range(9) == 0) req[1] = ~req[1];
            if ($urandom_range(3) == 0) drv_busy = ~drv_busy;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
